fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, 4, prefetch queue entries (power of two, 2..16).
REQ-002 Parameter MAX_OUT, 2, maximum outstanding instruction-memory requests (1..3).
REQ-003 Parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 is_flush  in  1  redirect request from branch resolution.
REQ-007 branch_target  in  32  redirect PC, sampled when is_flush=1.
REQ-008 is_stall  in  1  downstream (IF/ID) not accepting this cycle.
REQ-009 req_valid  out  1  instruction-memory read request.
REQ-010 req_addr  out  32  word-aligned fetch address.
REQ-011 req_ready  in  1  memory accepts request; transfer when req_valid & req_ready.
REQ-012 rsp_valid  in  1  read data returned, in request order, latency >=1 cycle.
REQ-013 rsp_data  in  32  instruction word.
REQ-014 is_valid  out  1  pc/instr hold a valid instruction.
REQ-015 pc  out  32  PC of presented instruction.
REQ-016 instr  out  32  presented instruction.

Function
REQ-017 Queue SHALL be a DEPTH-entry FIFO of {pc, instr}; outputs SHALL present the head entry, registered (no combinational path from rsp_* to outputs).
REQ-018 is_valid SHALL equal queue-not-empty; head SHALL be popped when is_valid=1 and is_stall=0.
REQ-019 FSM states: BOOT, FETCH, DRAIN.
REQ-020 BOOT: entered on reset, no requests; SHALL move to FETCH after exactly one clock.
REQ-021 FETCH: req_valid SHALL assert iff count + inflight < DEPTH and inflight < MAX_OUT, with count/inflight the registered values (no same-cycle pop or response credit).
REQ-022 On each accepted request, fetch PC SHALL advance by 4 (32-bit wrap at 32'hFFFF_FFFC -> 0) and inflight SHALL increment; each rsp_valid SHALL decrement inflight.
REQ-023 In FETCH, each response SHALL be pushed with its issue PC (tracked by an in-order PC FIFO of MAX_OUT entries).
REQ-024 Simultaneous push and pop SHALL keep count unchanged; overflow SHALL be impossible by REQ-021.
REQ-025 is_flush=1 (any state) SHALL: empty queue, force req_valid=0 that cycle, load fetch PC with branch_target, set drop_cnt = inflight minus any response that cycle, enter DRAIN if drop_cnt>0 else FETCH.
REQ-026 DRAIN: no requests; each rsp_valid SHALL be discarded and decrement drop_cnt; leave to FETCH in the cycle after drop_cnt reaches 0.
REQ-027 is_flush SHALL take priority over is_stall, pop, push and request issue in the same cycle.
REQ-028 is_stall=1 SHALL hold is_valid/pc/instr stable; fetching SHALL continue until queue credits are exhausted.

Reset
REQ-029 reset=0 SHALL immediately clear: queue (count=0), inflight=0, drop_cnt=0, state=BOOT, fetch PC=RESET_PC, is_valid=0, pc=0, instr=0, req_valid=0, req_addr=RESET_PC.
REQ-030 Reset asserted mid-operation SHALL abandon in-flight responses; memory SHALL be reset concurrently.

Configuration
REQ-031 Macro FETCH_QUEUE_PERF_EN defined: add outputs stall_cycles (32) counting cycles with is_valid=1 & is_stall=1, and dropped_cnt (32) counting entries discarded by flush plus responses dropped in DRAIN; both saturate at 32'hFFFF_FFFF and reset to 0.
REQ-032 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-033 Reset release, req_ready=1, 1-cycle latency memory returning addr as data -> first is_valid at cycle 3, pc=0, instr=0, then pc 4, 8, 12 one per cycle.
REQ-034 is_stall held 10 cycles with DEPTH=4 -> queue fills, req_valid=0, outputs stable at same pc; on release 4 consecutive pcs emerge without bubbles.
REQ-035 Flush with branch_target=32'h100 while 2 requests in flight -> queue empties next cycle, 2 responses discarded, next presented pc=32'h100.
REQ-036 is_flush and is_stall and rsp_valid in same cycle -> flush wins; no stale entry ever presented.
REQ-037 RESET_PC=32'hFFFF_FFF8 -> pcs FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-038 Reset asserted with queue full and 2 in flight -> all outputs cleared asynchronously; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: issues in-order memory reads, buffers {pc, instr} pairs, handles redirects.
// Optional performance counters are compiled in with `define FETCH_QUEUE_PERF_EN.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        is_flush,
    input  logic [31:0] branch_target,
    input  logic        is_stall,
    output logic        req_valid,
    output logic [31:0] req_addr,
    input  logic        req_ready,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_data,
    output logic        is_valid,
    output logic [31:0] pc,
    output logic [31:0] instr
`ifdef FETCH_QUEUE_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] dropped_cnt
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        DRAIN
    } state_t;

    state_t        state, state_next;
    logic [31:0]   fetch_pc;
    logic [CW-1:0] count;
    logic [PW-1:0] head, tail;
    logic [31:0]   q_pc    [DEPTH];
    logic [31:0]   q_instr [DEPTH];
    logic [1:0]    inflight;
    logic [1:0]    drop_cnt, drop_next;
    logic [1:0]    pf_rd, pf_wr;
    logic [31:0]   pf_mem  [4];

    logic issue, push, pop, rsp_dec;

    // Issue-PC FIFO holds MAX_OUT entries, which need not be a power of two.
    function automatic logic [1:0] pf_inc(input logic [1:0] p);
        if (32'(p) >= MAX_OUT - 1) return 2'd0;
        return p + 2'd1;
    endfunction

    always_comb begin
        req_valid = (state == FETCH) && !is_flush
                    && ((32'(count) + 32'(inflight)) < DEPTH)
                    && (32'(inflight) < MAX_OUT);
        req_addr  = fetch_pc;
        issue     = req_valid && req_ready;
        push      = (state == FETCH) && rsp_valid && !is_flush;
        pop       = is_valid && !is_stall && !is_flush;
        rsp_dec   = rsp_valid && (inflight != '0);
    end

    always_comb begin
        is_valid = (count != '0);
        pc       = is_valid ? q_pc[head]    : '0;
        instr    = is_valid ? q_instr[head] : '0;
    end

    always_comb begin
        state_next = state;
        drop_next  = drop_cnt;
        unique case (state)
            BOOT:  state_next = FETCH;
            FETCH: state_next = FETCH;
            DRAIN: begin
                if (rsp_valid && (drop_cnt != '0)) drop_next = drop_cnt - 2'd1;
                if (drop_next == '0) state_next = FETCH;
            end
            default: state_next = BOOT;
        endcase
        // A response arriving with the flush is already accounted for, so it is not dropped again.
        if (is_flush) begin
            drop_next  = inflight - 2'(rsp_dec);
            state_next = (drop_next != '0) ? DRAIN : FETCH;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= BOOT;
            fetch_pc <= RESET_PC;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
            inflight <= '0;
            drop_cnt <= '0;
            pf_rd    <= '0;
            pf_wr    <= '0;
        end else begin
            state    <= state_next;
            drop_cnt <= drop_next;
            inflight <= inflight + 2'(issue) - 2'(rsp_dec);
            if (is_flush) begin
                fetch_pc <= {branch_target[31:2], 2'b00};
                count    <= '0;
                head     <= '0;
                tail     <= '0;
                pf_rd    <= pf_wr;
            end else begin
                if (issue) begin
                    fetch_pc <= fetch_pc + 32'd4;
                    pf_wr    <= pf_inc(pf_wr);
                end
                if (push) begin
                    tail  <= tail + 1'b1;
                    pf_rd <= pf_inc(pf_rd);
                end
                if (pop) head <= head + 1'b1;
                if (push && !pop)      count <= count + 1'b1;
                else if (pop && !push) count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[tail]    <= pf_mem[pf_rd];
            q_instr[tail] <= rsp_data;
        end
        if (issue) pf_mem[pf_wr] <= fetch_pc;
    end

`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] drop_add;
    logic [32:0] drop_sum;

    always_comb begin
        drop_add = '0;
        if (is_flush)                                    drop_add = 32'(count) + 32'(rsp_valid);
        else if ((state == DRAIN) && rsp_valid && (drop_cnt != '0)) drop_add = 32'd1;
        drop_sum = {1'b0, dropped_cnt} + {1'b0, drop_add};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
            dropped_cnt  <= '0;
        end else begin
            if (is_valid && is_stall && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 32'd1;
            dropped_cnt <= drop_sum[32] ? '1 : drop_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized traffic against a stream model.
module tb_fetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam int unsigned MAX_OUT  = 2;
    localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        is_flush = 1'b0;
    logic [31:0] branch_target = '0;
    logic        is_stall = 1'b0;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready = 1'b0;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = '0;
    logic        is_valid;
    logic [31:0] pc;
    logic [31:0] instr;
`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] dropped_cnt;
`endif

    fetch_queue #(
        .DEPTH    (DEPTH),
        .MAX_OUT  (MAX_OUT),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .is_flush      (is_flush),
        .branch_target (branch_target),
        .is_stall      (is_stall),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .is_valid      (is_valid),
        .pc            (pc),
        .instr         (instr)
`ifdef FETCH_QUEUE_PERF_EN
        ,
        .stall_cycles  (stall_cycles),
        .dropped_cnt   (dropped_cnt)
`endif
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned pops  = 0;

    // Reference: the program-order stream the core must see, and the memory's outstanding reads.
    logic [31:0] exp_pc;
    logic [31:0] exp_issue;
    logic [31:0] pending[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    // rsp_mode: 0 = random latency, 1 = answer whenever something is pending, 2 = hold all responses
    task automatic step(input bit stall, input bit flush, input logic [31:0] target,
                        input bit ready, input int rsp_mode);
        bit rsp_now;
        @(negedge clk);
        if (is_valid) begin
            check_eq("pc", pc, exp_pc);
            check_eq("instr", instr, exp_pc);
        end
        is_stall      = stall;
        is_flush      = flush;
        branch_target = target;
        req_ready     = ready;
        case (rsp_mode)
            0:       rsp_now = (pending.size() > 0) && ($urandom_range(0, 9) < 7);
            1:       rsp_now = (pending.size() > 0);
            default: rsp_now = 1'b0;
        endcase
        rsp_valid = rsp_now;
        rsp_data  = rsp_now ? pending[0] : 32'hDEAD_BEEF;
        #1;
        if (flush) check_eq("flush_req", 32'(req_valid), 32'd0);
        if (req_valid && req_ready) begin
            check_eq("req_addr", req_addr, exp_issue);
            check_eq("max_out", 32'(pending.size() < MAX_OUT), 32'd1);
        end
        if (flush) begin
            exp_pc    = target;
            exp_issue = target;
        end else if (is_valid && !stall) begin
            exp_pc = exp_pc + 32'd4;
            pops++;
        end
        if (rsp_now) void'(pending.pop_front());
        if (req_valid && req_ready) begin
            pending.push_back(req_addr);
            exp_issue = exp_issue + 32'd4;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_valid"}, 32'(is_valid), 32'd0);
        check_eq({tag, "_pc"}, pc, 32'd0);
        check_eq({tag, "_instr"}, instr, 32'd0);
        check_eq({tag, "_req_valid"}, 32'(req_valid), 32'd0);
        check_eq({tag, "_req_addr"}, req_addr, RESET_PC);
    endtask

    task automatic release_reset();
        @(negedge clk);
        is_stall  = 1'b0;
        is_flush  = 1'b0;
        rsp_valid = 1'b0;
        req_ready = 1'b1;
        reset     = 1'b1;
        exp_pc    = RESET_PC;
        exp_issue = RESET_PC;
        pending.delete();
    endtask

    task automatic wait_valid(input string tag, input logic [31:0] want_pc);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step(0, 0, '0, 1, 1);
            seen = is_valid;
        end
        check_eq({tag, "_timeout"}, 32'(seen), 32'd1);
        check_eq({tag, "_pc"}, pc, want_pc);
    endtask

    initial begin
        logic [31:0] tgt;
        int unsigned pops_before;

        exp_pc    = RESET_PC;
        exp_issue = RESET_PC;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");

        // Startup latency and address wrap from RESET_PC
        release_reset();
        step(0, 0, '0, 1, 1);
        check_eq("boot_c1_valid", 32'(is_valid), 32'd0);
        step(0, 0, '0, 1, 1);
        check_eq("c2_valid", 32'(is_valid), 32'd0);
        step(0, 0, '0, 1, 1);
        check_eq("c3_valid", 32'(is_valid), 32'd1);
        check_eq("c3_pc", pc, 32'hFFFF_FFF8);
        step(0, 0, '0, 1, 1);
        check_eq("c4_pc", pc, 32'hFFFF_FFFC);
        step(0, 0, '0, 1, 1);
        check_eq("c5_pc", pc, 32'h0000_0000);
        step(0, 0, '0, 1, 1);
        check_eq("c6_pc", pc, 32'h0000_0004);

        // Long stall fills the queue; release drains it without bubbles
        for (int i = 0; i < 10; i++) step(1, 0, '0, 1, 1);
        check_eq("stall_full_req", 32'(req_valid), 32'd0);
        check_eq("stall_full_valid", 32'(is_valid), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, '0, 1, 1);
            check_eq("no_bubble", 32'(is_valid), 32'd1);
        end

        // Redirect with two reads outstanding
        for (int i = 0; i < 4; i++) step(0, 0, '0, 1, 2);
        step(0, 1, 32'h100, 1, 2);
        step(0, 0, '0, 1, 2);
        check_eq("flush_empty", 32'(is_valid), 32'd0);
        check_eq("drain_no_req", 32'(req_valid), 32'd0);
        wait_valid("redirect", 32'h100);

        // Flush, stall and response together
        for (int i = 0; i < 3; i++) step(0, 0, '0, 1, 1);
        step(1, 1, 32'h200, 1, 1);
        step(0, 0, '0, 1, 1);
        check_eq("flush_stall_empty", 32'(is_valid), 32'd0);
        wait_valid("flush_stall", 32'h200);

        // Asynchronous reset in the middle of traffic
        for (int i = 0; i < 3; i++) step(1, 0, '0, 1, 2);
        #2;
        reset     = 1'b0;
        rsp_valid = 1'b0;
        is_stall  = 1'b0;
        #1;
        check_reset_outputs("async");
        pending.delete();
        repeat (2) @(posedge clk);
        release_reset();
        step(0, 0, '0, 1, 1);
        step(0, 0, '0, 1, 1);
        step(0, 0, '0, 1, 1);
        check_eq("restart_valid", 32'(is_valid), 32'd1);
        check_eq("restart_pc", pc, RESET_PC);

        // Randomized traffic
        pops_before = pops;
        for (int i = 0; i < 3000; i++) begin
            tgt = $urandom();
            tgt = tgt & 32'hFFFF_FFFC;
            step($urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0, tgt,
                 $urandom_range(0, 3) != 0, 0);
        end
        check_eq("progress", 32'((pops - pops_before) > 300), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
